// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared widths, r0 constant and writeback entry type for the regfile write scheduler.
package rf_sched_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int STARVE_MAX_DEF = 4;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_write_sched_if.sv
// regfile_write_sched_if: writer, decode and regfile-port signals of the write scheduler.
interface regfile_write_sched_if;
  import rf_sched_pkg::*;
  logic              alu_wr_valid;
  logic [ADDR_W-1:0] alu_wr_addr;
  logic [DATA_W-1:0] alu_wr_data;
  logic              mdu_wr_valid;
  logic              mdu_wr_ready;
  logic [ADDR_W-1:0] mdu_wr_addr;
  logic [DATA_W-1:0] mdu_wr_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dst;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              rd_stall;
  logic              waw_stall;
  logic              starve_stall;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  modport master (
    output alu_wr_valid, alu_wr_addr, alu_wr_data, mdu_wr_valid, mdu_wr_addr, mdu_wr_data,
           issue_valid, issue_dst, rd_addr1, rd_addr2,
    input  mdu_wr_ready, rd_stall, waw_stall, starve_stall, rf_waddr, rf_wdata, rf_we
  );
  modport slave (
    input  alu_wr_valid, alu_wr_addr, alu_wr_data, mdu_wr_valid, mdu_wr_addr, mdu_wr_data,
           issue_valid, issue_dst, rd_addr1, rd_addr2,
    output mdu_wr_ready, rd_stall, waw_stall, starve_stall, rf_waddr, rf_wdata, rf_we
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO of writeback entries; wrap-bit pointers distinguish full from empty.
module wb_fifo import rf_sched_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  wb_entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/regfile_write_sched.sv
// regfile_write_sched: arbitrates the single regfile write port between ALU and buffered MDU, tracks pending MDU destinations.
module regfile_write_sched import rf_sched_pkg::*; #(
  parameter int BUF_DEPTH  = 2,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_write_sched_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic full, empty, push, pop, alu_win, fifo_commit, hit;
  wb_entry_t head, nxt, out_q;
  logic we_q, starve_q;
  logic [NREG-1:0] pending, set_v, clr_v;
  logic [CW-1:0] cnt, cnt_nxt;
  assign alu_win = bus.alu_wr_valid && bus.alu_wr_addr != REG_ZERO;
  assign pop = !alu_win && !empty;
  assign push = bus.mdu_wr_valid && !full;
  assign fifo_commit = pop && head.addr != REG_ZERO;
  wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din(wb_entry_t'{addr: bus.mdu_wr_addr, data: bus.mdu_wr_data}),
    .dout(head), .full(full), .empty(empty)
  );
  // r0 entries from the FIFO are consumed but committed as idle writes
  assign nxt = alu_win ? wb_entry_t'{addr: bus.alu_wr_addr, data: bus.alu_wr_data} : fifo_commit ? head : '0;
  assign set_v = (bus.issue_valid && bus.issue_dst != REG_ZERO) ? NREG'(1) << bus.issue_dst : '0;
  assign clr_v = fifo_commit ? NREG'(1) << head.addr : '0;
  assign hit = alu_win && !empty && cnt == CW'(STARVE_MAX - 1);
  assign cnt_nxt = (pop || empty || hit) ? '0 : cnt + CW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      we_q <= 1'b0;
      starve_q <= 1'b0;
      cnt <= '0;
      pending <= '0;
    end else begin
      out_q <= nxt;
      we_q <= alu_win || fifo_commit;
      starve_q <= hit;
      cnt <= cnt_nxt;
      pending <= (pending & ~clr_v) | set_v;
    end
  end
  assign bus.mdu_wr_ready = !full;
  assign bus.rd_stall = pending[bus.rd_addr1] | pending[bus.rd_addr2];
  assign bus.waw_stall = bus.issue_valid & pending[bus.issue_dst];
  assign bus.starve_stall = starve_q;
  assign bus.rf_waddr = out_q.addr;
  assign bus.rf_wdata = out_q.data;
  assign bus.rf_we = we_q;
endmodule

// File: tb/tb_regfile_write_sched.sv
// tb_regfile_write_sched: table-driven directed vectors plus an asynchronous mid-queue reset sequence.
module tb_regfile_write_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cmp = 0;
  int errs = 0;
  regfile_write_sched_if bus();
  regfile_write_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic iv; logic [4:0] id;
    logic [4:0] r1, r2;
    logic ery, erd, ewaw;
    logic [4:0] ea; logic [31:0] ed; logic ewe, est;
  } vec_t;
  vec_t v[24];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic iv, input logic [4:0] id, input logic [4:0] r1, input logic [4:0] r2);
    bus.alu_wr_valid = av; bus.alu_wr_addr = aa; bus.alu_wr_data = ad;
    bus.mdu_wr_valid = mv; bus.mdu_wr_addr = ma; bus.mdu_wr_data = md;
    bus.issue_valid = iv; bus.issue_dst = id; bus.rd_addr1 = r1; bus.rd_addr2 = r2;
  endtask

  initial begin
    //      av aa  ad      mv ma md      iv id  r1 r2  ery erd ewaw ea  ed      we st
    v[0]  = '{0, 0,  0,      0, 0, 0,      0, 0,  0, 0,  1, 0, 0,   0,  0,      0, 0};
    v[1]  = '{0, 0,  0,      0, 0, 0,      1, 8,  8, 0,  1, 0, 0,   0,  0,      0, 0};
    v[2]  = '{0, 0,  0,      1, 8, 'hA5,   0, 0,  8, 0,  1, 1, 0,   0,  0,      0, 0};
    v[3]  = '{0, 0,  0,      0, 0, 0,      0, 0,  8, 0,  1, 1, 0,   8,  'hA5,   1, 0};
    v[4]  = '{0, 0,  0,      0, 0, 0,      0, 0,  8, 0,  1, 0, 0,   0,  0,      0, 0};
    v[5]  = '{1, 3,  'h11,   1, 4, 'h22,   0, 0,  0, 0,  1, 0, 0,   3,  'h11,   1, 0};
    v[6]  = '{0, 0,  0,      0, 0, 0,      0, 0,  0, 0,  1, 0, 0,   4,  'h22,   1, 0};
    v[7]  = '{1, 20, 'h100,  1, 11, 1,     0, 0,  0, 0,  1, 0, 0,   20, 'h100,  1, 0};
    v[8]  = '{1, 21, 'h101,  1, 12, 2,     0, 0,  0, 0,  1, 0, 0,   21, 'h101,  1, 0};
    v[9]  = '{1, 22, 'h102,  1, 13, 3,     0, 0,  0, 0,  0, 0, 0,   22, 'h102,  1, 0};
    v[10] = '{1, 23, 'h103,  1, 13, 3,     0, 0,  0, 0,  0, 0, 0,   23, 'h103,  1, 0};
    v[11] = '{1, 24, 'h104,  1, 13, 3,     0, 0,  0, 0,  0, 0, 0,   24, 'h104,  1, 1};
    v[12] = '{0, 0,  0,      1, 13, 3,     0, 0,  0, 0,  0, 0, 0,   11, 1,      1, 0};
    v[13] = '{0, 0,  0,      1, 13, 3,     0, 0,  0, 0,  1, 0, 0,   12, 2,      1, 0};
    v[14] = '{0, 0,  0,      0, 0, 0,      0, 0,  0, 0,  1, 0, 0,   13, 3,      1, 0};
    v[15] = '{0, 0,  0,      1, 5, 'h33,   0, 0,  0, 0,  1, 0, 0,   0,  0,      0, 0};
    v[16] = '{1, 0,  'h77,   0, 0, 0,      0, 0,  0, 0,  1, 0, 0,   5,  'h33,   1, 0};
    v[17] = '{0, 0,  0,      1, 0, 'hFF,   0, 0,  0, 0,  1, 0, 0,   0,  0,      0, 0};
    v[18] = '{0, 0,  0,      0, 0, 0,      0, 0,  0, 0,  1, 0, 0,   0,  0,      0, 0};
    v[19] = '{0, 0,  0,      0, 0, 0,      1, 9,  0, 0,  1, 0, 0,   0,  0,      0, 0};
    v[20] = '{0, 0,  0,      1, 9, 'h99,   0, 0,  9, 0,  1, 1, 0,   0,  0,      0, 0};
    v[21] = '{0, 0,  0,      0, 0, 0,      1, 9,  0, 0,  1, 0, 1,   9,  'h99,   1, 0};
    v[22] = '{0, 0,  0,      0, 0, 0,      0, 0,  9, 0,  1, 1, 0,   0,  0,      0, 0};
    v[23] = '{0, 0,  0,      0, 0, 0,      1, 0,  0, 9,  1, 1, 0,   0,  0,      0, 0};
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset rf_waddr", 32'(bus.rf_waddr), 0);
    chk("reset rf_wdata", bus.rf_wdata, 0);
    chk("reset rf_we", 32'(bus.rf_we), 0);
    chk("reset starve_stall", 32'(bus.starve_stall), 0);
    chk("reset mdu_wr_ready", 32'(bus.mdu_wr_ready), 1);
    chk("reset rd_stall", 32'(bus.rd_stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(v[i].av, v[i].aa, v[i].ad, v[i].mv, v[i].ma, v[i].md, v[i].iv, v[i].id, v[i].r1, v[i].r2);
      #1;
      chk($sformatf("v%0d mdu_wr_ready", i), 32'(bus.mdu_wr_ready), 32'(v[i].ery));
      chk($sformatf("v%0d rd_stall", i), 32'(bus.rd_stall), 32'(v[i].erd));
      chk($sformatf("v%0d waw_stall", i), 32'(bus.waw_stall), 32'(v[i].ewaw));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rf_waddr", i), 32'(bus.rf_waddr), 32'(v[i].ea));
      chk($sformatf("v%0d rf_wdata", i), bus.rf_wdata, v[i].ed);
      chk($sformatf("v%0d rf_we", i), 32'(bus.rf_we), 32'(v[i].ewe));
      chk($sformatf("v%0d starve_stall", i), 32'(bus.starve_stall), 32'(v[i].est));
    end
    // Fill the FIFO behind ALU writes, then reset asynchronously mid-queue
    @(negedge clk);
    drive(1, 1, 'hAA, 1, 14, 'hE, 1, 16, 16, 9);
    @(negedge clk);
    drive(1, 2, 'hBB, 1, 15, 'hF, 0, 0, 16, 9);
    @(posedge clk);
    #1;
    chk("preq rf_we", 32'(bus.rf_we), 1);
    chk("preq mdu_wr_ready", 32'(bus.mdu_wr_ready), 0);
    chk("preq rd_stall", 32'(bus.rd_stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rf_we", 32'(bus.rf_we), 0);
    chk("async rf_waddr", 32'(bus.rf_waddr), 0);
    chk("async rf_wdata", bus.rf_wdata, 0);
    chk("async mdu_wr_ready", 32'(bus.mdu_wr_ready), 1);
    chk("async rd_stall", 32'(bus.rd_stall), 0);
    chk("async starve_stall", 32'(bus.starve_stall), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 16, 16, 9);
    rst_n = 1'b1;
    #1;
    chk("post waw_stall", 32'(bus.waw_stall), 0);
    @(posedge clk);
    #1;
    chk("post rf_we", 32'(bus.rf_we), 0);
    chk("post rf_waddr", 32'(bus.rf_waddr), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
